// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and a maskable IRQ.
// Optional prescaler on the decrement is enabled by defining TIMER_PRESCALE_EN.
module timer_counter #(
  parameter logic [31:0] RESET_PRESET = 32'd0,
  parameter int          COUNT_W      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

  localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

  state_t               state;
  logic                 en;
  logic [1:0]           mode;
  logic                 im;
  logic [COUNT_W-1:0]   preset;
  logic [COUNT_W-1:0]   count;
  logic                 irq_flag;
  logic                 tick;
  logic [31:0]          ctrl_rd;
  logic                 unused_addr;

`ifdef TIMER_PRESCALE_EN
  logic [1:0] ps;
  logic [2:0] ps_cnt;
  logic [2:0] ps_max;

  always_comb begin
    ps_max = 3'd0;
    case (ps)
      2'd0:    ps_max = 3'd0;
      2'd1:    ps_max = 3'd1;
      2'd2:    ps_max = 3'd3;
      default: ps_max = 3'd7;
    endcase
  end

  assign tick    = (ps_cnt == ps_max);
  assign ctrl_rd = {26'd0, ps, im, mode, en};
`else
  assign tick    = 1'b1;
  assign ctrl_rd = {28'd0, im, mode, en};
`endif

  assign unused_addr = ^Addr[31:4];
  assign IRQ         = im & irq_flag;

  // FSM and register file share one block so a CPU write can override the FSM on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      en       <= 1'b0;
      mode     <= 2'd0;
      im       <= 1'b0;
      preset   <= RESET_PRESET[COUNT_W-1:0];
      count    <= '0;
      irq_flag <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      ps       <= 2'd0;
      ps_cnt   <= 3'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (en) state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
`ifdef TIMER_PRESCALE_EN
          ps_cnt <= 3'd0;
`endif
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (tick) begin
            if (count > ONE) begin
              count <= count - ONE;
            end else begin
              count    <= '0;
              irq_flag <= 1'b1;
              state    <= INT;
            end
          end
`ifdef TIMER_PRESCALE_EN
          if (tick) ps_cnt <= 3'd0;
          else      ps_cnt <= ps_cnt + 3'd1;
`endif
        end
        INT: begin
          // auto-reload drops the flag and leaves EN set so IDLE reloads; one-shot stops
          if (mode == 2'd1) irq_flag <= 1'b0;
          else              en       <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (WE) begin
        case (Addr[3:2])
          2'b00: begin
            en       <= Din[0];
            mode     <= Din[2:1];
            im       <= Din[3];
            irq_flag <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            ps       <= Din[5:4];
`endif
          end
          2'b01: begin
            preset   <= Din[COUNT_W-1:0];
            irq_flag <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (Addr[3:2])
      2'b00:   Dout = ctrl_rd;
      2'b01:   Dout[COUNT_W-1:0] = preset;
      2'b10:   Dout[COUNT_W-1:0] = count;
      default: Dout = 32'd0;
    endcase
  end

endmodule
